// File: rtl/ifetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_queue_pkg
//   Shared constants for the instruction fetch unit:
//   - RV32I major opcodes used by the fetch pre-decoder
//   - fetch FSM state encoding
//   - instruction queue entry layout
//   - sign-extended J/B immediate extraction helpers
// ---------------------------------------------------------------------------
package ifetch_queue_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARITHR = 7'b0110011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CACHE,
        ST_WAIT_PRED,
        ST_WAIT_JALR,
        ST_DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } iq_entry_t;

    // J-type immediate, sign-extended from bit 20
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended from bit 12
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_queue_inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//   Circular FIFO of pre-decoded fetch entries (inst, pc, predicted-taken).
//   Ports:
//     i_clk, i_rst, i_rdy    clock, sync active-high reset, global enable
//     i_enq, i_enq_entry     push request and entry
//     i_deq                  pop request (ignored when empty)
//     i_flush                empty the queue; beats push and pop
//     o_head_valid           queue not empty
//     o_head_entry           head entry (all zero when empty)
//     o_count                number of stored entries
// ---------------------------------------------------------------------------
module inst_queue
    import ifetch_queue_pkg::*;
#(
    parameter int IQ_DEPTH_LOG = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rdy,
    input  logic                  i_enq,
    input  iq_entry_t             i_enq_entry,
    input  logic                  i_deq,
    input  logic                  i_flush,
    output logic                  o_head_valid,
    output iq_entry_t             o_head_entry,
    output logic [IQ_DEPTH_LOG:0] o_count
);

    localparam int                    DEPTH   = 1 << IQ_DEPTH_LOG;
    localparam logic [IQ_DEPTH_LOG:0] IQ_FULL = {1'b1, {IQ_DEPTH_LOG{1'b0}}};

    iq_entry_t               r_mem [DEPTH];
    logic [IQ_DEPTH_LOG-1:0] r_head;
    logic [IQ_DEPTH_LOG-1:0] r_tail;
    logic [IQ_DEPTH_LOG:0]   r_count;

    logic w_do_deq;
    logic w_do_enq;

    assign w_do_deq = i_deq && (r_count != '0);
    // A pop in the same cycle frees the slot a full queue would otherwise lack
    assign w_do_enq = i_enq && ((r_count != IQ_FULL) || w_do_deq);

    // Storage carries no reset; empty-queue outputs are masked below instead
    always_ff @(posedge i_clk) begin
        if (i_rdy && !i_rst && !i_flush && w_do_enq) begin
            r_mem[r_tail] <= i_enq_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_rdy) begin
            if (i_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_do_enq) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_do_deq) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_do_enq, w_do_deq})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign o_head_valid = (r_count != '0);
    assign o_head_entry = o_head_valid ? r_mem[r_head] : '0;
    assign o_count      = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//   Single-outstanding instruction fetch with control-flow pre-decode feeding
//   a circular instruction queue towards the decoder.
//   Ports:
//     clk_in, rst_in, rdy_in     clock, sync active-high reset, global enable
//     icache_req, icache_pc      fetch request (held until have_result)
//     have_result, inst_from_icache  icache response
//     pred_pc, predict           branch predictor query / taken answer
//     dec_valid/inst/pc/pred     queue head towards the decoder
//     dec_ready                  decoder consumes head
//     jalr_valid, jalr_target    resolved target for a stalled JALR
//     flush, flush_pc            ROB redirect
// ---------------------------------------------------------------------------
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          IQ_DEPTH_LOG = 3,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req,
    output logic [31:0] icache_pc,
    input  logic        have_result,
    input  logic [31:0] inst_from_icache,
    output logic [31:0] pred_pc,
    input  logic        predict,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        dec_pred,
    input  logic        dec_ready,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam logic [IQ_DEPTH_LOG:0] IQ_FULL = {1'b1, {IQ_DEPTH_LOG{1'b0}}};

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_icache_req;
    logic [31:0]  r_icache_pc;
    logic [31:0]  r_pred_pc;
    logic [31:0]  r_br_inst;

    logic [6:0]            w_opcode;
    logic                  w_enq;
    iq_entry_t             w_enq_entry;
    iq_entry_t             w_head;
    logic                  w_head_valid;
    logic [IQ_DEPTH_LOG:0] w_iq_count;

    assign w_opcode = inst_from_icache[6:0];

    // Branches are held back one cycle so the prediction can join the entry
    always_comb begin
        w_enq            = 1'b0;
        w_enq_entry.inst = inst_from_icache;
        w_enq_entry.pc   = r_pc;
        w_enq_entry.pred = 1'b0;
        case (r_state)
            ST_WAIT_CACHE: begin
                if (have_result && (w_opcode != OP_BR)) begin
                    w_enq = 1'b1;
                end
            end
            ST_WAIT_PRED: begin
                w_enq            = 1'b1;
                w_enq_entry.inst = r_br_inst;
                w_enq_entry.pred = predict;
            end
            default: ;
        endcase
    end

    inst_queue #(
        .IQ_DEPTH_LOG(IQ_DEPTH_LOG)
    ) u_inst_queue (
        .i_clk       (clk_in),
        .i_rst       (rst_in),
        .i_rdy       (rdy_in),
        .i_enq       (w_enq),
        .i_enq_entry (w_enq_entry),
        .i_deq       (dec_ready),
        .i_flush     (flush),
        .o_head_valid(w_head_valid),
        .o_head_entry(w_head),
        .o_count     (w_iq_count)
    );

    // Branch instruction waiting for its prediction
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rst_in && !flush && (r_state == ST_WAIT_CACHE) &&
            have_result && (w_opcode == OP_BR)) begin
            r_br_inst <= inst_from_icache;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_icache_req <= 1'b0;
            r_icache_pc  <= 32'h0;
            r_pred_pc    <= 32'h0;
        end else if (rdy_in) begin
            if (flush) begin
                r_pc <= flush_pc;
                // A request still in flight must have its late data swallowed
                if (r_icache_req && !have_result) begin
                    r_state <= ST_DISCARD;
                end else begin
                    r_state      <= ST_IDLE;
                    r_icache_req <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // One fetch in flight at most, so a free slot now is a free slot at arrival
                        if (w_iq_count < IQ_FULL) begin
                            r_icache_req <= 1'b1;
                            r_icache_pc  <= r_pc;
                            r_state      <= ST_WAIT_CACHE;
                        end
                    end
                    ST_WAIT_CACHE: begin
                        if (have_result) begin
                            r_icache_req <= 1'b0;
                            case (w_opcode)
                                OP_JAL: begin
                                    r_pc    <= r_pc + imm_j(inst_from_icache);
                                    r_state <= ST_IDLE;
                                end
                                OP_JALR: begin
                                    r_state <= ST_WAIT_JALR;
                                end
                                OP_BR: begin
                                    r_pred_pc <= r_pc;
                                    r_state   <= ST_WAIT_PRED;
                                end
                                default: begin
                                    r_pc    <= r_pc + 32'd4;
                                    r_state <= ST_IDLE;
                                end
                            endcase
                        end
                    end
                    ST_WAIT_PRED: begin
                        r_pc    <= predict ? (r_pc + imm_b(r_br_inst)) : (r_pc + 32'd4);
                        r_state <= ST_IDLE;
                    end
                    ST_WAIT_JALR: begin
                        if (jalr_valid) begin
                            r_pc    <= jalr_target;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_DISCARD: begin
                        if (have_result) begin
                            r_icache_req <= 1'b0;
                            r_state      <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign icache_req = r_icache_req;
    assign icache_pc  = r_icache_pc;
    assign pred_pc    = r_pred_pc;
    assign dec_valid  = w_head_valid;
    assign dec_inst   = w_head.inst;
    assign dec_pc     = w_head.pc;
    assign dec_pred   = w_head.pred;

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Parametrised next-generation instruction fetch unit.
- Fetches one instruction per icache transaction and pre-decodes it for control flow: JAL redirect, branch prediction query, JALR stall.
- Buffers fetched instructions in a circular queue of configurable depth, so fetch runs ahead of the decoder.
- Sits between icache, predictor, decoder and ROB; ROB redirect flushes queue and in-flight fetch.

Parameters:
IQ_DEPTH_LOG, 3, log2 of queue entries (8 entries)
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global pause when low; all state frozen
icache_req  output  1  request valid (level, held until have_result)
icache_pc  output  32  fetch address
have_result  input  1  icache data valid this cycle
inst_from_icache  input  32  fetched instruction
pred_pc  output  32  branch PC sent to predictor
predict  input  1  taken guess, valid the cycle after pred_pc changes
dec_valid  output  1  queue head valid
dec_inst  output  32  head instruction
dec_pc  output  32  head PC
dec_pred  output  1  head predicted-taken flag (0 for non-branches)
dec_ready  input  1  decoder accepts head this cycle
jalr_valid  input  1  ROB resolved the stalled JALR target
jalr_target  input  32  JALR target
flush  input  1  ROB misprediction redirect
flush_pc  input  32  redirect target

Behaviour:
- Reset values: icache_req=0, icache_pc=0, pred_pc=0, pc=RESET_PC, queue empty (head=tail=count=0), dec_valid=0, dec_inst=0, dec_pc=0, dec_pred=0, FSM=IDLE.
- rdy_in=0: no register changes. Inputs are ignored, including flush.
- FSM states: IDLE, WAIT_CACHE, WAIT_PRED, WAIT_JALR, DISCARD.
- IDLE:
  - If count < DEPTH: icache_req<=1, icache_pc<=pc, go to WAIT_CACHE.
  - Else stay. Only one fetch is outstanding at a time, so space is guaranteed at arrival.
- WAIT_CACHE, on have_result: icache_req<=0, then opcode = inst_from_icache[6:0]:
  - JAL (1101111): enqueue {inst, pc, 0}; pc <= pc + J-imm; go to IDLE.
  - JALR (1100111): enqueue {inst, pc, 0}; go to WAIT_JALR.
  - BRANCH (1100011): latch inst into a temporary register; pred_pc<=pc; go to WAIT_PRED.
  - Other: enqueue {inst, pc, 0}; pc<=pc+4; go to IDLE.
- WAIT_PRED (exactly 1 cycle):
  - Enqueue {temp, pc, predict}.
  - pc <= predict ? pc + B-imm : pc+4.
  - Go to IDLE.
- WAIT_JALR: on jalr_valid, pc<=jalr_target, go to IDLE. Otherwise hold.
- DISCARD: wait for have_result, drop the data, icache_req<=0, go to IDLE.
- Immediates are sign-extended to 32 bits. All PC arithmetic is mod 2^32, and wrap is legal.
- Queue:
  - Circular, head/tail pointers IQ_DEPTH_LOG bits wide, wrap naturally.
  - count is IQ_DEPTH_LOG+1 bits.
  - dec_valid = (count != 0). dec_* reflect the head entry combinationally from the storage array.
  - Dequeue when dec_valid && dec_ready.
  - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
  - Dequeue on empty is ignored.
- Flush (highest priority, beats every FSM action and enqueue in the same cycle):
  - Queue emptied; pc<=flush_pc.
  - If an icache request is outstanding and have_result is not this cycle: go to DISCARD. Otherwise go to IDLE.
  - A have_result coinciding with flush is dropped.
  - Flush while in WAIT_PRED or WAIT_JALR abandons the branch/JALR.
  - jalr_valid in the same cycle as flush is ignored.
- Reset mid-transaction: everything returns to reset values. Any stale have_result after reset is ignored, because the FSM is IDLE.

Decomposition:
- Shared const package (existing const.v): opcode localparams (LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, ARITHR, ARITHI) and FSM state encodings.
- Sub-module inst_queue: parametrised circular FIFO, with enq/deq/flush inputs and head data/valid/count outputs.
- ifetch_queue keeps the FSM, PC, and immediate decode.

Test Plan:
- Straight-line fetch, icache 1-cycle latency, dec_ready=1:
  - PCs 0,4,8,12 reach the decoder in order with dec_pred=0.
  - One instruction is issued every 2 cycles.
- dec_ready=0 with IQ_DEPTH_LOG=2:
  - After 4 enqueues, icache_req stays 0 while count==4.
  - Raise dec_ready: fetch resumes at PC 16, and no entry is lost or duplicated.
- Branch at PC 8 with imm +16, predict=1:
  - Entry {pc=8, pred=1} is queued.
  - Next icache_pc = 24.
  - Repeat with predict=0: next icache_pc = 12.
- JAL at PC 4 with imm -4: entry queued, next icache_pc=0. JALR at PC 0: no new fetch until jalr_valid with target 0x100, then icache_pc=0x100.
- Flush while WAIT_CACHE outstanding, flush_pc=0x200:
  - Queue empties immediately; dec_valid=0 next cycle.
  - The late have_result data never appears at dec_inst.
  - Next icache_pc=0x200.
- rdy_in low for 5 cycles mid-WAIT_PRED: state, queue and outputs are frozen. Resuming yields an identical sequence to the unpaused run.
